mem_stage: RTL

Memory-access stage of the five-stage pipeline: accepts one `mem_params_t` per cycle from the EX/MEM register, performs word loads and stores on the data bus via a req/ack handshake, and produces `wb_params_t` for the writeback stage. While a bus access is outstanding it stalls upstream. It also exposes the MEM/WB forwarding source (`FW_SEL_MEM_WB`) and a pending-load indication for the hazard unit.

---
 rtl/types_pkg.sv | 59 +++++
 rtl/mem_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/types_pkg.sv
// ============================================================================
// Module  : types (package)
// Brief   : Shared pipeline types for the memory stage and its neighbours.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package types;

    typedef logic [3:0] wrstb_t;

    // Encoding 2'b11 is left unnamed; consumers treat it as NONE.
    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_LOAD  = 2'b01,
        MEM_OP_STORE = 2'b10
    } mem_op_e;

    typedef enum logic [1:0] {
        FW_SEL_NONE   = 2'b00,
        FW_SEL_EX_MEM = 2'b01,
        FW_SEL_MEM_WB = 2'b10
    } fw_sel_e;

    typedef enum logic [0:0] {
        MEM_ST_IDLE = 1'b0,
        MEM_ST_BUS  = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        mem_op_e     mem_op;
        logic [31:0] mem_data;
    } mem_params_t;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
    } wb_params_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        wrstb_t      wrstb;
    } dbus_req_t;

    localparam wrstb_t      c_WRSTB_WORD = 4'hF;
    localparam logic [31:0] c_WORD_MASK  = 32'hFFFF_FFFC;

    function automatic logic is_mem_access(input mem_op_e op);
        return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module  : mem_stage
// Brief   : Pipeline memory-access stage: word loads/stores over a req/ack
//           data bus, MEM/WB forwarding source (FW_SEL_MEM_WB) and load hazard
//           indication. Optional macro MEM_STAGE_ALIGN_CHECK_EN enables the
//           misaligned-access trap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  mem_params_t in_params,
    output logic        in_ready,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output wrstb_t      dbus_wrstb,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        out_valid,
    output wb_params_t  out_params,
    output logic [4:0]  fw_rd_addr,
    output logic [31:0] fw_rd_data,
    output logic        fw_load_pending,
    output logic [4:0]  fw_load_rd,
    output logic        align_err
);

    mem_state_e  r_state;
    mem_state_e  w_state_next;
    mem_params_t r_op;
    logic        r_out_valid;
    wb_params_t  r_out_params;
    logic        r_align_err;
    dbus_req_t   w_dbus;
    logic        w_accept;
    logic        w_access;
    logic        w_misaligned;
    logic        w_bus_done;

    assign w_accept   = in_valid && (r_state == MEM_ST_IDLE);
    assign w_access   = is_mem_access(in_params.mem_op);
    assign w_bus_done = (r_state == MEM_ST_BUS) && dbus_ack;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign w_misaligned = (in_params.rd_data[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // State register; reset drops dbus_req immediately and abandons the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MEM_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MEM_ST_IDLE: begin
                if (w_accept && w_access && !w_misaligned) begin
                    w_state_next = MEM_ST_BUS;
                end
            end
            MEM_ST_BUS: begin
                if (dbus_ack) begin
                    w_state_next = MEM_ST_IDLE;
                end
            end
            default: w_state_next = MEM_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready        = 1'b0;
        w_dbus          = '0;
        fw_load_pending = 1'b0;
        fw_load_rd      = 5'd0;
        case (r_state)
            MEM_ST_IDLE: begin
                in_ready = 1'b1;
            end
            MEM_ST_BUS: begin
                w_dbus.req   = 1'b1;
                w_dbus.we    = (r_op.mem_op == MEM_OP_STORE);
                w_dbus.addr  = r_op.rd_data & c_WORD_MASK;
                w_dbus.wdata = r_op.mem_data;
                w_dbus.wrstb = (r_op.mem_op == MEM_OP_STORE) ? c_WRSTB_WORD : 4'h0;
                if (r_op.mem_op == MEM_OP_LOAD) begin
                    fw_load_pending = 1'b1;
                    fw_load_rd      = r_op.rd_addr;
                end
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign dbus_req   = w_dbus.req;
    assign dbus_we    = w_dbus.we;
    assign dbus_addr  = w_dbus.addr;
    assign dbus_wdata = w_dbus.wdata;
    assign dbus_wrstb = w_dbus.wrstb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op <= '0;
        end else if (w_accept && w_access) begin
            r_op <= in_params;
        end
    end

    // Result register: every completion (pass-through, bus, or trap) pulses one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_params <= '0;
            r_align_err  <= 1'b0;
        end else begin
            r_out_valid  <= 1'b0;
            r_out_params <= '0;
            r_align_err  <= 1'b0;
            if (w_accept && !w_access) begin
                r_out_valid          <= 1'b1;
                r_out_params.rd_addr <= in_params.rd_addr;
                r_out_params.rd_data <= in_params.rd_data;
            end else if (w_accept && w_misaligned) begin
                r_out_valid <= 1'b1;
                r_align_err <= 1'b1;
            end else if (w_bus_done) begin
                r_out_valid <= 1'b1;
                if (r_op.mem_op == MEM_OP_LOAD) begin
                    r_out_params.rd_addr <= r_op.rd_addr;
                    r_out_params.rd_data <= dbus_rdata;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_params = r_out_params;
    assign align_err  = r_align_err;
    assign fw_rd_addr = r_out_valid ? r_out_params.rd_addr : 5'd0;
    assign fw_rd_data = r_out_valid ? r_out_params.rd_data : 32'd0;

endmodule

`default_nettype wire
